byte_striping: RTL and testbench

BYTE_STRIPING -- requirements
Module: byte_striping

---
 rtl/byte_striping.sv | 66 ++++++
 tb/tb_byte_striping.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/byte_striping.sv
// Transmit-side byte striper: splits one byte stream into two lanes, even-position
// bytes on stripe 0 and odd-position bytes on stripe 1, with fully registered outputs.
module byte_striping #(
    parameter int DATA_W = 8
) (
    input  logic              clk_2f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              flush,
    output logic [DATA_W-1:0] data_stripe_0,
    output logic [DATA_W-1:0] data_stripe_1,
    output logic              valid_stripe_0,
    output logic              valid_stripe_1,
    output logic              pending
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] hold;

    assign pending = (state == HALF);

    // NOTE: the hold register is reset too, so a byte held at reset can never leak out later.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            state          <= EMPTY;
            hold           <= '0;
            data_stripe_0  <= '0;
            data_stripe_1  <= '0;
            valid_stripe_0 <= 1'b0;
            valid_stripe_1 <= 1'b0;
        end else begin
            valid_stripe_0 <= 1'b0;
            valid_stripe_1 <= 1'b0;
            case (state)
                EMPTY: begin
                    if (valid_in) begin
                        hold  <= data_in;
                        state <= HALF;
                    end
                end
                HALF: begin
                    // A new byte completes the pair and wins over flush.
                    if (valid_in) begin
                        data_stripe_0  <= hold;
                        data_stripe_1  <= data_in;
                        valid_stripe_0 <= 1'b1;
                        valid_stripe_1 <= 1'b1;
                        state          <= EMPTY;
                    end else if (flush) begin
                        data_stripe_0  <= hold;
                        valid_stripe_0 <= 1'b1;
                        state          <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_striping.sv
// Self-checking bench for byte_striping: directed scenarios plus randomized traffic
// checked against a queue-based model and a stream reassembly (unstriping) check.
module tb_byte_striping;

    logic       clk_2f = 1'b0;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic       flush;
    logic [7:0] data_stripe_0;
    logic [7:0] data_stripe_1;
    logic       valid_stripe_0;
    logic       valid_stripe_1;
    logic       pending;

    int checks = 0;
    int errors = 0;

    // Reference model state: bytes accepted but not yet emitted, plus expected outputs.
    logic [7:0] held_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] recv_q[$];
    logic [7:0] exp_d0, exp_d1;
    logic       exp_v0, exp_v1;

    byte_striping #(.DATA_W(8)) dut (
        .clk_2f         (clk_2f),
        .reset_L        (reset_L),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .flush          (flush),
        .data_stripe_0  (data_stripe_0),
        .data_stripe_1  (data_stripe_1),
        .valid_stripe_0 (valid_stripe_0),
        .valid_stripe_1 (valid_stripe_1),
        .pending        (pending)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        held_q.delete();
        exp_d0 = '0;
        exp_d1 = '0;
        exp_v0 = 1'b0;
        exp_v1 = 1'b0;
    endtask

    // The stream is cut into consecutive pairs; a flush on an idle cycle ships a lone byte.
    task automatic model_step(input logic v, input logic [7:0] d, input logic f);
        exp_v0 = 1'b0;
        exp_v1 = 1'b0;
        if (v) begin
            held_q.push_back(d);
            sent_q.push_back(d);
        end
        if (held_q.size() == 2) begin
            exp_d0 = held_q[0];
            exp_d1 = held_q[1];
            exp_v0 = 1'b1;
            exp_v1 = 1'b1;
            held_q.delete();
        end else if (!v && f && held_q.size() == 1) begin
            exp_d0 = held_q[0];
            exp_v0 = 1'b1;
            held_q.delete();
        end
    endtask

    task automatic compare_outputs();
        check("valid_stripe_0", valid_stripe_0, exp_v0);
        check("valid_stripe_1", valid_stripe_1, exp_v1);
        check("data_stripe_0", data_stripe_0, exp_d0);
        check("data_stripe_1", data_stripe_1, exp_d1);
        check("pending", pending, (held_q.size() == 1));
        if (valid_stripe_0) recv_q.push_back(data_stripe_0);
        if (valid_stripe_1) recv_q.push_back(data_stripe_1);
    endtask

    // Called at a falling edge: drive, let the rising edge capture, check at the next falling edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic f);
        valid_in = v;
        data_in  = d;
        flush    = f;
        @(posedge clk_2f);
        model_step(v, d, f);
        @(negedge clk_2f);
        compare_outputs();
    endtask

    initial begin
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        flush    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_2f);
        compare_outputs();
        reset_L = 1'b1;

        // Continuous bytes: pairs two cycles apart, one-cycle pulses.
        cycle(1'b1, 8'hA1, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0);
        check("pair0_d0", data_stripe_0, 8'hA1);
        check("pair0_d1", data_stripe_1, 8'hB2);
        cycle(1'b1, 8'hC3, 1'b0);
        check("pulse_width", valid_stripe_0, 1'b0);
        cycle(1'b1, 8'hD4, 1'b0);
        check("pair1_d1", data_stripe_1, 8'hD4);
        cycle(1'b0, 8'h00, 1'b0);

        // Idle gap inside a pair.
        cycle(1'b1, 8'h11, 1'b0);
        repeat (3) begin
            cycle(1'b0, 8'hEE, 1'b0);
            check("gap_pending", pending, 1'b1);
        end
        cycle(1'b1, 8'h22, 1'b0);
        check("gap_pair_d0", data_stripe_0, 8'h11);
        check("gap_pair_d1", data_stripe_1, 8'h22);

        // Flush a lone byte; stripe 1 keeps 0x22.
        cycle(1'b1, 8'h5A, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        check("flush_d0", data_stripe_0, 8'h5A);
        check("flush_d1_held", data_stripe_1, 8'h22);
        check("flush_v1", valid_stripe_1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b1, 8'h44, 1'b0);

        // Valid beats flush in HALF.
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b1);
        check("prio_d1", data_stripe_1, 8'h02);

        // Asynchronous reset with a byte held.
        cycle(1'b1, 8'h77, 1'b0);
        #2 reset_L = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        @(posedge clk_2f);
        @(negedge clk_2f);
        reset_L = 1'b1;
        compare_outputs();
        cycle(1'b1, 8'h88, 1'b0);
        cycle(1'b1, 8'h99, 1'b0);
        check("rst_pair_d0", data_stripe_0, 8'h88);

        // Randomized traffic with loopback reassembly.
        cycle(1'b0, 8'h00, 1'b0);
        sent_q.delete();
        recv_q.delete();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 4) == 0));
        end
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        check("loop_len", recv_q.size(), sent_q.size());
        for (int i = 0; i < sent_q.size() && i < recv_q.size(); i++) begin
            if (recv_q[i] !== sent_q[i]) check("loop_byte", recv_q[i], sent_q[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
